// File: rtl/parser_layer_stage.sv
`default_nettype none
// ============================================================================
// Module      : parser_layer_stage
// Description : One parser layer. Looks up the protocol type field against a
//               small rule table, copies selected 16-bit header fields into
//               free metadata slots and strips the parsed layer from the
//               header window. Three-stage pipeline, one beat per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module parser_layer_stage #(
  parameter int HEAD_WIDTH = 512,
  parameter int META_WIDTH = 256,
  parameter int RULE_NUM   = 8,
  parameter int KEY_NUM    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rule_wren,
  input  logic                  i_rule_rden,
  input  logic [31:0]           i_rule_addr,
  input  logic [31:0]           i_rule_wdata,
  output logic                  o_rule_rdata_valid,
  output logic [31:0]           o_rule_rdata,
  input  logic                  i_valid,
  input  logic [HEAD_WIDTH-1:0] i_head,
  input  logic [META_WIDTH-1:0] i_meta,
  input  logic [5:0]            i_type_offset,
  input  logic [4:0]            i_meta_offset,
  output logic                  o_valid,
  output logic [HEAD_WIDTH-1:0] o_head,
  output logic [META_WIDTH-1:0] o_meta,
  output logic [5:0]            o_type_offset,
  output logic [4:0]            o_meta_offset,
  output logic                  o_miss,
  output logic                  o_meta_ovf
);

  localparam int IDX_W = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
  localparam int SLOTS = META_WIDTH / 16;

  // Rule table, stored as decoded fields so unused word bits never exist.
  logic               rule_valid   [RULE_NUM];
  logic [15:0]        rule_value   [RULE_NUM];
  logic [15:0]        rule_mask    [RULE_NUM];
  logic [KEY_NUM-1:0] rule_key_v   [RULE_NUM];
  logic [5:0]         rule_next    [RULE_NUM];
  logic [5:0]         rule_shift   [RULE_NUM];
  logic [5:0]         rule_key_off [RULE_NUM][KEY_NUM];

  logic [1:0]       addr_word;
  logic [IDX_W-1:0] addr_idx;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign addr_word   = i_rule_addr[1:0];
  assign addr_idx    = i_rule_addr[2 +: IDX_W];
  assign unused_bits = ^{i_rule_addr[31:2+IDX_W], i_rule_wdata};

  // 16-bit field at byte offset b; bytes past the window shift in as zero.
  function automatic logic [15:0] field16(input logic [HEAD_WIDTH-1:0] h,
                                          input logic [5:0] b);
    logic [HEAD_WIDTH-1:0] t;
    t = h << {b, 3'b000};
    return t[HEAD_WIDTH-1 -: 16];
  endfunction

  // Rule table write port; the table is wiped on reset so every lookup misses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        rule_valid[r] <= 1'b0;
        rule_value[r] <= '0;
        rule_mask[r]  <= '0;
        rule_key_v[r] <= '0;
        rule_next[r]  <= '0;
        rule_shift[r] <= '0;
        for (int k = 0; k < KEY_NUM; k++) rule_key_off[r][k] <= '0;
      end
    end else if (i_rule_wren) begin
      case (addr_word)
        2'd0: begin
          rule_valid[addr_idx] <= i_rule_wdata[31];
          rule_value[addr_idx] <= i_rule_wdata[15:0];
        end
        2'd1: rule_mask[addr_idx] <= i_rule_wdata[15:0];
        2'd2: begin
          rule_key_v[addr_idx] <= i_rule_wdata[16 +: KEY_NUM];
          rule_next[addr_idx]  <= i_rule_wdata[13:8];
          rule_shift[addr_idx] <= i_rule_wdata[5:0];
        end
        default: begin
          for (int k = 0; k < KEY_NUM; k++)
            rule_key_off[addr_idx][k] <= i_rule_wdata[8*k +: 6];
        end
      endcase
    end
  end

  // Re-pack the addressed word from its stored fields; unused bits read 0.
  always_comb begin
    rd_word = '0;
    case (addr_word)
      2'd0: begin
        rd_word[31]   = rule_valid[addr_idx];
        rd_word[15:0] = rule_value[addr_idx];
      end
      2'd1: rd_word[15:0] = rule_mask[addr_idx];
      2'd2: begin
        rd_word[16 +: KEY_NUM] = rule_key_v[addr_idx];
        rd_word[13:8]          = rule_next[addr_idx];
        rd_word[5:0]           = rule_shift[addr_idx];
      end
      default: begin
        for (int k = 0; k < KEY_NUM; k++)
          rd_word[8*k +: 6] = rule_key_off[addr_idx][k];
      end
    endcase
  end

  // Registered read port; samples the table before a same-cycle write lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= '0;
    end else begin
      o_rule_rdata_valid <= i_rule_rden;
      o_rule_rdata       <= i_rule_rden ? rd_word : 32'd0;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic                  s1_valid;
  logic [HEAD_WIDTH-1:0] s1_head;
  logic [META_WIDTH-1:0] s1_meta;
  logic [15:0]           s1_type;
  logic [5:0]            s1_toff;
  logic [4:0]            s1_moff;

  // Capture the beat and pull out its type field.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_head  <= '0;
      s1_meta  <= '0;
      s1_type  <= '0;
      s1_toff  <= '0;
      s1_moff  <= '0;
    end else begin
      s1_valid <= i_valid;
      s1_head  <= i_head;
      s1_meta  <= i_meta;
      s1_type  <= field16(i_head, i_type_offset);
      s1_toff  <= i_type_offset;
      s1_moff  <= i_meta_offset;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  // Priority match: the lowest-index valid rule that matches wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      if (!hit && rule_valid[r] &&
          ((s1_type & rule_mask[r]) == (rule_value[r] & rule_mask[r]))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(r);
      end
    end
  end

  logic                  s2_valid;
  logic [HEAD_WIDTH-1:0] s2_head;
  logic [META_WIDTH-1:0] s2_meta;
  logic [5:0]            s2_toff;
  logic [4:0]            s2_moff;
  logic                  s2_miss;
  logic [KEY_NUM-1:0]    s2_key_v;
  logic [5:0]            s2_next;
  logic [5:0]            s2_shift;
  logic [5:0]            s2_key_off [KEY_NUM];

  // Latch the winning rule's action fields alongside the beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_head  <= '0;
      s2_meta  <= '0;
      s2_toff  <= '0;
      s2_moff  <= '0;
      s2_miss  <= 1'b0;
      s2_key_v <= '0;
      s2_next  <= '0;
      s2_shift <= '0;
      for (int k = 0; k < KEY_NUM; k++) s2_key_off[k] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_head  <= s1_head;
      s2_meta  <= s1_meta;
      s2_toff  <= s1_toff;
      s2_moff  <= s1_moff;
      s2_miss  <= !hit;
      s2_key_v <= rule_key_v[hit_idx];
      s2_next  <= rule_next[hit_idx];
      s2_shift <= rule_shift[hit_idx];
      for (int k = 0; k < KEY_NUM; k++) s2_key_off[k] <= rule_key_off[hit_idx][k];
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [HEAD_WIDTH-1:0] nx_head;
  logic [META_WIDTH-1:0] nx_meta;
  logic [5:0]            nx_toff;
  logic [4:0]            nx_moff;
  logic                  nx_ovf;
  logic [5:0]            slot_cnt;
  logic [15:0]           key_field;

  // Pack enabled keys into consecutive free slots and strip the layer.
  always_comb begin
    nx_head   = s2_head;
    nx_meta   = s2_meta;
    nx_toff   = s2_toff;
    nx_moff   = s2_moff;
    nx_ovf    = 1'b0;
    slot_cnt  = {1'b0, s2_moff};
    key_field = '0;
    if (!s2_miss) begin
      nx_head = s2_head << {s2_shift, 3'b000};
      nx_toff = s2_next;
      for (int k = 0; k < KEY_NUM; k++) begin
        if (s2_key_v[k]) begin
          key_field = field16(s2_head, s2_key_off[k]);
          if (slot_cnt < 6'(SLOTS)) begin
            for (int s = 0; s < SLOTS; s++) begin
              if (slot_cnt == 6'(s)) nx_meta[META_WIDTH-16*(s+1) +: 16] = key_field;
            end
          end else begin
            nx_ovf = 1'b1;
          end
          slot_cnt = slot_cnt + 6'd1;
        end
      end
      nx_moff = (slot_cnt > 6'(SLOTS)) ? 5'(SLOTS) : slot_cnt[4:0];
    end
  end

  // Output register; status flags only qualify valid beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid       <= 1'b0;
      o_head        <= '0;
      o_meta        <= '0;
      o_type_offset <= '0;
      o_meta_offset <= '0;
      o_miss        <= 1'b0;
      o_meta_ovf    <= 1'b0;
    end else begin
      o_valid       <= s2_valid;
      o_head        <= nx_head;
      o_meta        <= nx_meta;
      o_type_offset <= nx_toff;
      o_meta_offset <= nx_moff;
      o_miss        <= s2_valid & s2_miss;
      o_meta_ovf    <= s2_valid & nx_ovf;
    end
  end

endmodule
`default_nettype wire

// File: doc/parser_layer_stage.md
# parser_layer_stage

Single-layer parser stage that runs in the opposite direction to the deparser layer. It takes a packet header window and its metadata, extracts the protocol type field, matches it against a configurable rule table, and copies the selected key fields from the header into the metadata. It then strips the parsed layer from the header and passes the next layer's type offset downstream. Instances are chained one per protocol layer in the parser pipeline and share the 32-bit rule-configuration bus used by the deparser layers.

## Interface
Parameters:
- HEAD_WIDTH, 512: header window width in bits. Byte 0 is bits [HEAD_WIDTH-1 -: 8].
- META_WIDTH, 256: metadata width in bits, organised as 16-bit slots. Slot 0 is the MSBs.
- RULE_NUM, 8: number of rule entries; must be a power of 2.
- KEY_NUM, 4: number of key-field extractors per rule. Each key field is 16 bits.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rule_wren  in  1  rule write strobe.
- i_rule_rden  in  1  rule read strobe.
- i_rule_addr  in  32  [1:0] selects the word; [2 +: log2(RULE_NUM)] selects the rule; upper bits are ignored.
- i_rule_wdata  in  32  rule write data.
- o_rule_rdata_valid  out  1  read data valid.
- o_rule_rdata  out  32  read data.
- i_valid  in  1  input beat valid. No backpressure.
- i_head  in  HEAD_WIDTH  header window.
- i_meta  in  META_WIDTH  metadata in.
- i_type_offset  in  6  byte offset of the 16-bit type field in i_head.
- i_meta_offset  in  5  next free meta slot, range 0..16.
- o_valid  out  1  output beat valid.
- o_head  out  HEAD_WIDTH  header shifted left by head_shift bytes, zero-filled.
- o_meta  out  META_WIDTH  metadata with the extracted keys inserted.
- o_type_offset  out  6  next_type_offset from the matched rule; i_type_offset on a miss.
- o_meta_offset  out  5  meta offset after insertion.
- o_miss  out  1  no rule matched.
- o_meta_ovf  out  1  at least one key was dropped because the metadata was full.

## Operation
- Rule word layout, per rule:
  - w0: [31] valid, [15:0] type_value.
  - w1: [15:0] type_mask.
  - w2: [KEY_NUM+15:16] key_v, [13:8] next_type_offset, [5:0] head_shift in bytes.
  - w3: key_offset[k] at [8k+5 : 8k], in bytes.
  - Unused bits are written as ignored and read back as 0.
- Rule writes take effect at the clock edge. Reads return the addressed word one cycle after i_rule_rden. o_rule_rdata is 0 when no read is pending.
- Field extraction: a 16-bit field at byte offset b is header bytes {b, b+1}. Any byte at position 64 or above reads as 0.
- Stage 1 registers:
  - the type field at i_type_offset;
  - head, meta, meta_offset, type_offset and valid.
- Stage 2 match: a rule hits when valid && ((type & type_mask) == (type_value & type_mask)). The lowest-index hit wins. The stage registers the winning rule's w2/w3 contents and the miss flag.
- Stage 3 output:
  - Extract each key k where key_v[k]=1.
  - Valid keys are packed in ascending k into consecutive slots starting at meta_offset.
  - A key whose slot would be 16 or higher is dropped and sets o_meta_ovf.
  - All other meta slots pass through unchanged.
  - o_meta_offset = min(meta_offset + number of valid keys, 16).
  - o_head = head << (8 × head_shift).
- Miss: o_head = head, o_meta = meta, offsets unchanged, o_miss = 1, o_meta_ovf = 0.
- When a beat is invalid, data still flows through the pipeline, but o_valid = 0 and o_miss/o_meta_ovf are forced to 0.

## Timing
- Data latency is exactly 3 cycles from i_valid to o_valid. Full throughput: one beat per cycle, back to back.
- Rule read latency is 1 cycle.
- Reset (async assert, synchronous deassert handled externally):
  - all outputs are 0;
  - all rule words are 0, so every rule is invalid and every lookup misses;
  - in-flight beats are discarded, and o_valid stays 0 for 3 cycles after release unless new beats are issued.
- A rule write in the same cycle as a beat's stage-2 lookup: the lookup uses the old table contents. The beat after it sees the new contents.
- Simultaneous i_rule_wren and i_rule_rden to the same word: the read returns the old value.

## Test plan
- Reset -> o_valid, o_head, o_meta, o_rule_rdata, o_miss all 0. Reading rule 0 w0 returns 0x00000000 one cycle later.
- Rule 0 configured as:
  - w0 = 0x80000800, w1 = 0xFFFF, w2 = key_v 0b0011, next 9, shift 14;
  - w3 = key offsets 26 and 30.
  
  Stimulus: beat with type_offset 12, bytes 12-13 = 0x0800, bytes 26-27 = 0xC0A8, bytes 30-31 = 0x0A00, meta_offset 2.
  
  Required 3 cycles later: slot 2 = 0xC0A8, slot 3 = 0x0A00, o_meta_offset 4, o_type_offset 9, o_head = i_head << 112 bits, o_miss 0.
- Type 0x86DD with no matching rule -> o_miss = 1, head and meta unchanged, offsets unchanged.
- Rules 1 and 3 both match 0x0800 (rule 3 uses mask 0xFF00) -> rule 1's shift and keys are applied.
- Rule 0 with meta_offset 15 and key_v 0b0011 -> slot 15 gets key 0, key 1 is dropped, o_meta_ovf = 1, o_meta_offset = 16.
- 5 back-to-back beats, with rule 0's w0 rewritten to type 0x86DD in the cycle of beat 2's lookup -> beat 2 matches the old rule, beats 3-5 use the new one. o_valid stays high for 5 consecutive cycles.
